// File: rtl/muldiv_iter_if.sv
// rtl/muldiv_iter_if.sv - start/busy/done handshake bundle for the iterative mul/div unit
interface muldiv_iter_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (output start, funct3, op_a, op_b, input busy, done, result);
  modport slave  (input start, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative RV32M multiply/divide, 32 iterations per op
module muldiv_iter (
  input  logic         clk,
  input  logic         rst,
  muldiv_iter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] opnd_q, opnd_d;    // multiplicand (mul) or divisor (div) magnitude
  logic [32:0] acc_q, acc_d;      // running high product / partial remainder
  logic [31:0] lo_q, lo_d;        // multiplier bits (mul) or dividend/quotient (div)
  logic        neg_q, neg_d;      // product or quotient must be negated
  logic        rneg_q, rneg_d;    // remainder must be negated
  logic [31:0] result_q, result_d;

  // Operand decode at the start edge: signedness, magnitudes, special cases
  logic        is_div_in, a_sgn_in, b_sgn_in, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, special_res;
  logic        div_zero, div_ovf;

  assign is_div_in = bus.funct3[2];
  // MUL's low half is sign-agnostic, so it shares MULH's signed path
  assign a_sgn_in  = is_div_in ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
  assign b_sgn_in  = is_div_in ? ~bus.funct3[0] : ~bus.funct3[1];
  assign a_neg     = a_sgn_in & bus.op_a[31];
  assign b_neg     = b_sgn_in & bus.op_b[31];
  assign a_mag     = a_neg ? (32'd0 - bus.op_a) : bus.op_a;
  assign b_mag     = b_neg ? (32'd0 - bus.op_b) : bus.op_b;
  assign div_zero  = is_div_in && (bus.op_b == 32'd0);
  assign div_ovf   = is_div_in && !bus.funct3[0] &&
                     (bus.op_a == 32'h8000_0000) && (bus.op_b == 32'hFFFF_FFFF);
  assign special_res = div_zero ? (bus.funct3[1] ? bus.op_a : 32'hFFFF_FFFF)
                                : (bus.funct3[1] ? 32'd0    : 32'h8000_0000);

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [32:0] acc_n;
  logic [31:0] lo_n;
  logic [63:0] prod, prod_s;
  logic [31:0] quo_s, rem_s, final_res;

  assign mul_sum   = {1'b0, acc_q[31:0]} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign div_shift = {acc_q[31:0], lo_q[31]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};

  // Select the next accumulator/low word for the active operation class
  always_comb begin
    acc_n = acc_q;
    lo_n  = lo_q;
    if (funct3_q[2]) begin
      if (!div_diff[33]) begin
        acc_n = div_diff[32:0];
        lo_n  = {lo_q[30:0], 1'b1};
      end else begin
        acc_n = div_shift;
        lo_n  = {lo_q[30:0], 1'b0};
      end
    end else begin
      acc_n = {1'b0, mul_sum[32:1]};
      lo_n  = {mul_sum[0], lo_q[31:1]};
    end
  end

  assign prod      = {acc_n[31:0], lo_n};
  assign prod_s    = neg_q ? (64'd0 - prod) : prod;
  assign quo_s     = neg_q ? (32'd0 - lo_n) : lo_n;
  assign rem_s     = rneg_q ? (32'd0 - acc_n[31:0]) : acc_n[31:0];
  assign final_res = funct3_q[2] ? (funct3_q[1] ? rem_s : quo_s)
                                 : ((funct3_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32]);

  // Next-state and datapath register updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          funct3_d = bus.funct3;
          cnt_d    = 5'd0;
          acc_d    = 33'd0;
          opnd_d   = is_div_in ? b_mag : a_mag;
          lo_d     = is_div_in ? a_mag : b_mag;
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = acc_n;
        lo_d  = lo_n;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = final_res;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      funct3_q <= 3'd0;
      opnd_q   <= 32'd0;
      acc_q    <= 33'd0;
      lo_q     <= 32'd0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == S_CALC);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - randomized self-checking bench for muldiv_iter
module tb_muldiv_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_iter_if bus();
  muldiv_iter dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected-behaviour state for the operation in flight
  bit          pending  = 1'b0;
  int          start_cyc;
  int          done_cyc;
  bit          exp_special;
  logic [31:0] exp_res;
  logic [31:0] held_res = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = 64'd0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 32'd0) ||
           (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Per-cycle compare: busy/done windows and the held result against the model
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      begin
        bit exp_busy, exp_done;
        exp_busy = pending && !exp_special && cyc >= start_cyc && cyc < start_cyc + 32;
        exp_done = pending && cyc == done_cyc;
        if (exp_done) held_res = exp_res;
        check("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
        check("done", {31'd0, bus.done}, {31'd0, exp_done});
        check("result", bus.result, held_res);
        if (exp_done) pending = 1'b0;
      end
    end
  end

  // Present one operation; start is sampled at the next rising edge
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.funct3  = f;
    bus.op_a    = a;
    bus.op_b    = b;
    start_cyc   = cyc + 1;
    exp_special = is_special(f, a, b);
    done_cyc    = exp_special ? start_cyc : start_cyc + 32;
    exp_res     = ref_model(f, a, b);
    pending     = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.funct3  = 3'($urandom);
    bus.op_a    = $urandom;
    bus.op_b    = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && pending; i++) @(negedge clk);
    checks++;
    if (pending) begin
      errors++;
      $display("FAIL timeout: done not seen, pending=%0d expected done at cycle %0d", pending, done_cyc);
      pending = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [2:0]  dir_f [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd5, 3'd6, 3'd4, 3'd6, 3'd7};
  logic [31:0] dir_a [14] = '{32'h7, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd100, 32'd100,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9};
  logic [31:0] dir_b [14] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'd3, 32'd3, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.funct3 = 3'd0;
    bus.op_a   = 32'd0;
    bus.op_b   = 32'd0;

    // Hand-computed values that pin the reference model
    check("pin_mul",    ref_model(3'd0, 32'h7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("pin_mulh",   ref_model(3'd1, 32'h7, 32'hFFFF_FFFD), 32'hFFFF_FFFF);
    check("pin_mulhu",  ref_model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("pin_mulhsu", ref_model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    check("pin_div",    ref_model(3'd4, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFA);
    check("pin_rem",    ref_model(3'd6, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFE);
    check("pin_divu",   ref_model(3'd5, 32'd100, 32'd7), 32'd14);
    check("pin_remu",   ref_model(3'd7, 32'd100, 32'd7), 32'd2);
    check("pin_divu0",  ref_model(3'd5, 32'd5, 32'd0), 32'hFFFF_FFFF);
    check("pin_rem0",   ref_model(3'd6, 32'd5, 32'd0), 32'd5);
    check("pin_ovf",    ref_model(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("pin_ovfrem", ref_model(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

    repeat (2) @(negedge clk);
    check("reset_busy",   {31'd0, bus.busy}, 32'd0);
    check("reset_done",   {31'd0, bus.done}, 32'd0);
    check("reset_result", bus.result, 32'd0);
    rst = 1'b0;

    // Directed operations from the test plan
    for (int i = 0; i < 14; i++) begin
      issue(dir_f[i], dir_a[i], dir_b[i]);
      wait_idle();
    end

    // Start pulses during CALC must be ignored
    issue(3'd5, 32'd1000, 32'd9);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd7; bus.op_a = 32'd50; bus.op_b = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("ignored_start_result", bus.result, 32'd111);

    // Asynchronous reset at iteration 10 of a running multiply
    issue(3'd0, 32'd123, 32'd456);
    while (cyc < start_cyc + 10) @(negedge clk);
    #2;
    pending  = 1'b0;
    held_res = 32'd0;
    rst      = 1'b1;
    #1;
    check("midreset_busy",   {31'd0, bus.busy}, 32'd0);
    check("midreset_done",   {31'd0, bus.done}, 32'd0);
    check("midreset_result", bus.result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd6, 32'd7);
    wait_idle();
    check("post_reset_mul", bus.result, 32'd42);

    // Randomized operations with corner-biased operands
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
